// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU decoder and the arbiter FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t;

  function automatic logic is_mul(input logic [2:0] ctrl);
    return ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin winner select; the last_grant register lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one multi-cycle ALU between the scalar pipeline (req 0) and the vector lane (req 1).
// Optional grant/contention statistics are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [1:0][2:0]       req_ctrl,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  output logic [1:0]            req_ready,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [WIDTH-1:0]      resp_result,
  output logic [2:0]            alu_ctrl,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_result,
  output logic                  busy,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1,
  output logic [15:0]           contend_cnt
);
  import alu_pkg::*;

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);

  alu_arb_state_t   state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             handshake;
  logic             win_idx;

  rr_arbiter2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign handshake = |(req_valid & req_ready);
  assign win_idx   = grant[1];
  assign busy      = (state != IDLE);

  // ALU operands are only written on accept, so they stay frozen through EXEC and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      alu_ctrl    <= 3'b000;
      alu_a       <= '0;
      alu_b       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            owner      <= win_idx;
            last_grant <= win_idx;
            alu_ctrl   <= req_ctrl[win_idx];
            alu_a      <= req_a[win_idx];
            alu_b      <= req_b[win_idx];
            cnt        <= is_mul(req_ctrl[win_idx]) ? MUL_CNT : '0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            resp_result <= alu_result;
            resp_valid  <= {owner, ~owner};
            state       <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[owner]) begin
            resp_valid <= 2'b00;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating counters so long runs never wrap back to small values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
      contend_cnt <= '0;
    end else if (handshake) begin
      if (!win_idx && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (win_idx && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
      if ((&req_valid) && contend_cnt != 16'hFFFF) contend_cnt <= contend_cnt + 16'd1;
    end
  end
`else
  assign grant_cnt0  = 16'h0000;
  assign grant_cnt1  = 16'h0000;
  assign contend_cnt = 16'h0000;
`endif

endmodule
